register_file_param: RTL and testbench
======================================

REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the width of each register and of each data port in bits.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 3, giving the address width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 The module SHALL have parameter ZERO_REG0, default 0; when 1, register 0 is hardwired to zero.
REQ-004 The module SHALL have parameter BYPASS, default 1; when 1, the write-to-read forward path of REQ-014 is present.
REQ-005 The module SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-006 The module SHALL have these ports:
  clock                 input   1           rising-edge clock
  reset                 input   1           synchronous active-high reset
  read_register_port_0  input   ADDR_WIDTH  read address, port 0
  read_register_port_1  input   ADDR_WIDTH  read address, port 1
  write_register        input   ADDR_WIDTH  write address
  write_data            input   DATA_WIDTH  write data
  write_enable          input   1           write strobe
  clear_request         input   1           start sequential clear of all registers
  read_data_port_0      output  DATA_WIDTH  read data, port 0 (combinational)
  read_data_port_1      output  DATA_WIDTH  read data, port 1 (combinational)
  busy                  output  1           clear sweep in progress
  write_rejected        output  1           one-cycle pulse: prior write dropped

Function
REQ-007 A write SHALL be accepted when write_enable=1 and busy=0; the addressed register takes write_data at that rising edge.
REQ-008 A write with write_enable=1 and busy=1 SHALL leave storage unchanged and SHALL set write_rejected=1 on the following cycle only.
REQ-009 When ZERO_REG0=1, an accepted write to address 0 SHALL be discarded without raising write_rejected, and reads of address 0 SHALL return 0.
REQ-010 Each read port SHALL independently return the addressed register contents combinationally, with zero cycles of latency.
REQ-011 The controller SHALL have two states, IDLE and CLEAR, plus a clear index counter of ADDR_WIDTH bits.
REQ-012 In IDLE with clear_request=1, the controller SHALL enter CLEAR at the next edge with index=0 and busy=1.
REQ-013 In CLEAR, each cycle SHALL zero register[index] and increment index; on the cycle index=DEPTH-1 that register SHALL be zeroed and the controller SHALL return to IDLE.
  - busy is high for exactly DEPTH cycles.
  - index does not wrap.
  - clear_request is ignored while in CLEAR.
REQ-014 When BYPASS=1, busy=0, write_enable=1 and write_register equals a read address (excluding address 0 when ZERO_REG0=1), that read port SHALL return write_data in the same cycle.
REQ-015 When BYPASS=0, a read of the register being written SHALL return the old value until the edge.
REQ-016 When clear_request=1 and write_enable=1 coincide in IDLE, the write SHALL be accepted and the clear SHALL then begin, so the written value is zeroed by the sweep.
REQ-017 During CLEAR, reads SHALL return current storage: swept entries read 0, and unswept entries read their old values.
REQ-018 Both read ports addressing the same register SHALL return identical data.

Reset
REQ-019 When reset=1 at a rising edge, all DEPTH registers SHALL become 0, the state SHALL become IDLE, index SHALL become 0, busy SHALL become 0 and write_rejected SHALL become 0.
REQ-020 Reset SHALL take priority over clear_request, write_enable and any in-progress CLEAR; asserting reset mid-sweep aborts the sweep, and after reset all registers are 0.
REQ-021 With reset=1, a concurrent write SHALL NOT be stored.

Verification
REQ-022 The bench SHALL cover: write 0xDEADBEEF to r5, then next cycle read port0=5 and port1=5 -> both read 0xDEADBEEF.
REQ-023 The bench SHALL cover, with BYPASS=1: write 0x12345678 to r3 while port0=3 -> read_data_port_0=0x12345678 in the same cycle; with BYPASS=0 -> the old value.
REQ-024 The bench SHALL cover: fill r0..r7 with nonzero values, pulse clear_request -> busy high for exactly 8 cycles, r0..r7 zeroed in order one per cycle, busy low on the 9th cycle.
REQ-025 The bench SHALL cover: write_enable=1 on the 3rd busy cycle -> storage unchanged, write_rejected=1 for exactly one cycle after.
REQ-026 The bench SHALL cover: with ZERO_REG0=1, write 0xFFFFFFFF to r0 -> r0 reads 0 and write_rejected stays 0.
REQ-027 The bench SHALL cover: assert reset on the 4th CLEAR cycle -> next cycle busy=0, all registers read 0, and a subsequent write succeeds.

Source files
------------

// File: rtl/register_file_param.sv
// ============================================================================
// Module   : register_file_param
// Brief    : Two-read/one-write register file with sequential clear sweep,
//            optional write-to-read forwarding and optional hardwired r0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module register_file_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG0  = 0,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_register_port_0,
    input  logic [ADDR_WIDTH-1:0] read_register_port_1,
    input  logic [ADDR_WIDTH-1:0] write_register,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    input  logic                  clear_request,
    output logic [DATA_WIDTH-1:0] read_data_port_0,
    output logic [DATA_WIDTH-1:0] read_data_port_1,
    output logic                  busy,
    output logic                  write_rejected
);

    localparam int                    c_depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_last  = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_index;
    logic                  r_busy;
    logic                  r_rejected;
    logic [DATA_WIDTH-1:0] r_mem [c_depth];

    logic                  w_write_accept;
    logic [ADDR_WIDTH-1:0] w_raddr [2];
    logic [DATA_WIDTH-1:0] w_rdata [2];

    // Writes to a hardwired r0 are silently dropped, not rejected.
    assign w_write_accept = write_enable && !r_busy &&
                            !((ZERO_REG0 != 0) && (write_register == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_index    <= '0;
            r_busy     <= 1'b0;
            r_rejected <= 1'b0;
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_rejected <= write_enable && r_busy;
            case (r_state)
                ST_IDLE: begin
                    // A write coinciding with the clear lands first and is swept later.
                    if (w_write_accept) begin
                        r_mem[write_register] <= write_data;
                    end
                    if (clear_request) begin
                        r_state <= ST_CLEAR;
                        r_index <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_mem[r_index] <= '0;
                    if (r_index == c_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_index <= r_index + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_raddr[0] = read_register_port_0;
    assign w_raddr[1] = read_register_port_1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
        logic w_zero;
        logic w_hit;
        assign w_zero = (ZERO_REG0 != 0) && (w_raddr[gi] == '0);
        assign w_hit  = (BYPASS != 0) && write_enable && !r_busy &&
                        (write_register == w_raddr[gi]);
        assign w_rdata[gi] = w_zero ? '0 :
                             w_hit  ? write_data :
                                      r_mem[w_raddr[gi]];
    end

    assign read_data_port_0 = w_rdata[0];
    assign read_data_port_1 = w_rdata[1];
    assign busy             = r_busy;
    assign write_rejected   = r_rejected;

endmodule

`default_nettype wire

// File: tb/tb_register_file_param.sv
// ============================================================================
// Module   : tb_register_file_param
// Brief    : Self-checking bench; three configurations share one stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_register_file_param;

    logic        clock = 1'b0;
    logic        reset, we, clr;
    logic [2:0]  ra0, ra1, wr;
    logic [31:0] wd;

    // Index 0: default (bypass), 1: BYPASS=0, 2: ZERO_REG0=1.
    logic [2:0][31:0] rd0, rd1;
    logic [2:0]       bsy, rej;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    register_file_param u_dut_byp (
        .clock(clock), .reset(reset),
        .read_register_port_0(ra0), .read_register_port_1(ra1),
        .write_register(wr), .write_data(wd), .write_enable(we),
        .clear_request(clr),
        .read_data_port_0(rd0[0]), .read_data_port_1(rd1[0]),
        .busy(bsy[0]), .write_rejected(rej[0])
    );

    register_file_param #(.BYPASS(0)) u_dut_nobyp (
        .clock(clock), .reset(reset),
        .read_register_port_0(ra0), .read_register_port_1(ra1),
        .write_register(wr), .write_data(wd), .write_enable(we),
        .clear_request(clr),
        .read_data_port_0(rd0[1]), .read_data_port_1(rd1[1]),
        .busy(bsy[1]), .write_rejected(rej[1])
    );

    register_file_param #(.ZERO_REG0(1)) u_dut_zero (
        .clock(clock), .reset(reset),
        .read_register_port_0(ra0), .read_register_port_1(ra1),
        .write_register(wr), .write_data(wd), .write_enable(we),
        .clear_request(clr),
        .read_data_port_0(rd0[2]), .read_data_port_1(rd1[2]),
        .busy(bsy[2]), .write_rejected(rej[2])
    );

    // Reference model: contents per configuration plus a sweep countdown.
    logic [31:0] m_mem [3][8];
    int          m_sweep_left = 0;
    int          m_sweep_pos  = 0;
    logic        m_rej        = 1'b0;

    function automatic logic [31:0] m_read(input int c, input logic [2:0] a);
        if (c == 2 && a == 3'd0) return 32'd0;
        if (c != 1 && m_sweep_left == 0 && we && wr == a) return wd;
        return m_mem[c][a];
    endfunction

    task automatic m_clock();
        if (reset) begin
            for (int c = 0; c < 3; c++)
                for (int a = 0; a < 8; a++) m_mem[c][a] = 32'd0;
            m_sweep_left = 0;
            m_sweep_pos  = 0;
            m_rej        = 1'b0;
        end else begin
            m_rej = we && (m_sweep_left > 0);
            if (m_sweep_left > 0) begin
                for (int c = 0; c < 3; c++) m_mem[c][m_sweep_pos] = 32'd0;
                m_sweep_pos++;
                m_sweep_left--;
            end else begin
                if (we)
                    for (int c = 0; c < 3; c++)
                        if (!(c == 2 && wr == 3'd0)) m_mem[c][wr] = wd;
                if (clr) begin
                    m_sweep_left = 8;
                    m_sweep_pos  = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        m_clock();
        #2;
    endtask

    function automatic logic [31:0] fill_val(input int c, input int a);
        if (c == 2 && a == 0) return 32'd0;
        return 32'hA500_0000 | 32'(a + 1);
    endfunction

    task automatic fill();
        for (int a = 0; a < 8; a++) begin
            we = 1'b1; wr = 3'(a); wd = fill_val(0, a);
            tick();
        end
        we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (bsy[0] === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL drain_timeout: busy still %b after %0d cycles, required 0", bsy[0], n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; we = 1'b1; wr = 3'd5; wd = 32'hBAD0_BAD0; clr = 1'b1;
        tick(); tick();
        reset = 1'b0; we = 1'b0; clr = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (bsy[c] !== 1'b0 || rej[c] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flags cfg%0d: busy=%b rej=%b, required 0 0", c, bsy[c], rej[c]);
            end
        end
        for (int a = 0; a < 8; a++) begin
            ra0 = 3'(a); ra1 = 3'(7 - a); #1;
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (rd0[c] !== 32'd0 || rd1[c] !== 32'd0) begin
                    n_fail++;
                    $display("FAIL reset_regs cfg%0d a=%0d: got %h/%h, required 0", c, a, rd0[c], rd1[c]);
                end
            end
        end
        tick();
    endtask

    task automatic test_write_read();
        we = 1'b1; wr = 3'd5; wd = 32'hDEAD_BEEF; ra0 = 3'd0; ra1 = 3'd1;
        tick();
        we = 1'b0; ra0 = 3'd5; ra1 = 3'd5; #1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (rd0[c] !== 32'hDEAD_BEEF || rd1[c] !== 32'hDEAD_BEEF) begin
                n_fail++;
                $display("FAIL write_read cfg%0d: got %h/%h, required deadbeef", c, rd0[c], rd1[c]);
            end
        end
        tick();
    endtask

    task automatic test_bypass();
        we = 1'b1; wr = 3'd3; wd = 32'hAAAA_5555;
        tick();
        wd = 32'h1234_5678; ra0 = 3'd3; #1;
        n_tests++;
        if (rd0[0] !== 32'h1234_5678 || rd0[2] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL bypass_fwd: got %h/%h, required 12345678", rd0[0], rd0[2]);
        end
        n_tests++;
        if (rd0[1] !== 32'hAAAA_5555) begin
            n_fail++;
            $display("FAIL bypass_off_old: got %h, required aaaa5555", rd0[1]);
        end
        tick();
        we = 1'b0; #1;
        n_tests++;
        if (rd0[1] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL bypass_off_after: got %h, required 12345678", rd0[1]);
        end
    endtask

    task automatic test_zero_reg0();
        we = 1'b1; wr = 3'd0; wd = 32'hFFFF_FFFF; ra0 = 3'd0; #1;
        n_tests++;
        if (rd0[2] !== 32'd0 || rd0[0] !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL zero_same_cycle: got zero=%h byp=%h, required 0 ffffffff", rd0[2], rd0[0]);
        end
        tick();
        we = 1'b0; #1;
        n_tests++;
        if (rd0[2] !== 32'd0 || rej[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_r0: got %h rej=%b, required 0 0", rd0[2], rej[2]);
        end
        n_tests++;
        if (rd0[0] !== 32'hFFFF_FFFF || rd0[1] !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL r0_normal: got %h/%h, required ffffffff", rd0[0], rd0[1]);
        end
        tick();
    endtask

    task automatic test_clear_sweep();
        fill();
        clr = 1'b1; #1;
        n_tests++;
        if (bsy !== 3'b000) begin
            n_fail++;
            $display("FAIL sweep_pre_busy: got %b, required 000", bsy);
        end
        tick();
        clr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ra0 = 3'(k); ra1 = (k == 0) ? 3'd7 : 3'(k - 1); #1;
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (bsy[c] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sweep_busy cfg%0d cyc%0d: got %b, required 1", c, k + 1, bsy[c]);
                end
                n_tests++;
                if (rd0[c] !== fill_val(c, k) ||
                    rd1[c] !== ((k == 0) ? fill_val(c, 7) : 32'd0)) begin
                    n_fail++;
                    $display("FAIL sweep_order cfg%0d cyc%0d: got %h/%h", c, k + 1, rd0[c], rd1[c]);
                end
            end
            tick();
        end
        #1;
        n_tests++;
        if (bsy !== 3'b000) begin
            n_fail++;
            $display("FAIL sweep_end_busy: got %b, required 000", bsy);
        end
        for (int a = 0; a < 8; a++) begin
            ra0 = 3'(a); #1;
            n_tests++;
            if (rd0 !== '0) begin
                n_fail++;
                $display("FAIL sweep_zeroed a=%0d: got %h, required 0", a, rd0);
            end
        end
    endtask

    task automatic test_reject();
        fill();
        clr = 1'b1; tick(); clr = 1'b0;
        tick(); tick();
        we = 1'b1; wr = 3'd6; wd = 32'h0BAD_F00D; ra0 = 3'd6; #1;
        n_tests++;
        if (rd0[0] !== fill_val(0, 6) || rej[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_during: got %h rej=%b", rd0[0], rej[0]);
        end
        tick();
        we = 1'b0; #1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (rej[c] !== 1'b1 || rd0[c] !== fill_val(c, 6)) begin
                n_fail++;
                $display("FAIL reject_pulse cfg%0d: rej=%b r6=%h, required 1 %h", c, rej[c], rd0[c], fill_val(c, 6));
            end
        end
        tick(); #1;
        n_tests++;
        if (rej !== 3'b000) begin
            n_fail++;
            $display("FAIL reject_one_cycle: got %b, required 000", rej);
        end
        drain(); #1;
        n_tests++;
        if (rd0 !== '0) begin
            n_fail++;
            $display("FAIL reject_final: got %h, required 0", rd0);
        end
    endtask

    task automatic test_reset_mid_clear();
        fill();
        clr = 1'b1; tick(); clr = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1; #1;
        n_tests++;
        if (bsy !== 3'b111) begin
            n_fail++;
            $display("FAIL mid_clear_busy: got %b, required 111", bsy);
        end
        tick();
        reset = 1'b0; #1;
        n_tests++;
        if (bsy !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset_busy: got %b, required 000", bsy);
        end
        for (int a = 0; a < 8; a++) begin
            ra0 = 3'(a); #1;
            n_tests++;
            if (rd0 !== '0) begin
                n_fail++;
                $display("FAIL mid_reset_regs a=%0d: got %h, required 0", a, rd0);
            end
        end
        we = 1'b1; wr = 3'd4; wd = 32'hC0FF_EE11;
        tick();
        we = 1'b0; ra0 = 3'd4; #1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (rd0[c] !== 32'hC0FF_EE11) begin
                n_fail++;
                $display("FAIL post_reset_write cfg%0d: got %h, required c0ffee11", c, rd0[c]);
            end
        end
    endtask

    task automatic test_clear_with_write();
        we = 1'b1; wr = 3'd7; wd = 32'h7777_7777; clr = 1'b1;
        tick();
        we = 1'b0; clr = 1'b0; ra0 = 3'd7; #1;
        n_tests++;
        if (bsy !== 3'b111 || rd0[0] !== 32'h7777_7777) begin
            n_fail++;
            $display("FAIL clear_write_start: busy=%b r7=%h, required 111 77777777", bsy, rd0[0]);
        end
        drain(); #1;
        n_tests++;
        if (rd0 !== '0) begin
            n_fail++;
            $display("FAIL clear_write_swept: got %h, required 0", rd0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            clr   = ($urandom_range(0, 19) == 0);
            we    = 1'($urandom_range(0, 1));
            wr    = 3'($urandom_range(0, 7));
            ra0   = 3'($urandom_range(0, 7));
            ra1   = ($urandom_range(0, 3) == 0) ? ra0 : 3'($urandom_range(0, 7));
            wd    = $urandom;
            #1;
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (rd0[c] !== m_read(c, ra0) || rd1[c] !== m_read(c, ra1) ||
                    bsy[c] !== (m_sweep_left > 0) || rej[c] !== m_rej) begin
                    n_fail++;
                    $display("FAIL random i=%0d cfg%0d: rd=%h/%h b=%b r=%b, required %h/%h b=%b r=%b",
                             i, c, rd0[c], rd1[c], bsy[c], rej[c],
                             m_read(c, ra0), m_read(c, ra1), (m_sweep_left > 0), m_rej);
                end
            end
            tick();
        end
        reset = 1'b0; clr = 1'b0; we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; clr = 1'b0;
        ra0 = '0; ra1 = '0; wr = '0; wd = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg0();
        test_clear_sweep();
        test_reject();
        test_reset_mid_clear();
        test_clear_with_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
